// File: rtl/lsu_biu_if.sv
// Load/store unit bus bundle: CPU request/response channels plus the byte-lane RAM port.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
// Ports: req_* (CPU -> unit), rsp_* (unit -> CPU), ram_* (unit <-> data RAM).
// modport slave: the lsu_biu side; modport master: the CPU/RAM environment side.
interface lsu_biu_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_addr_sel;
   logic [31:0]       ram_wr_data;
   logic [31:0]       ram_data_in;

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output ram_wr_en, ram_addr, ram_addr_sel, ram_wr_data,
      input  ram_data_in
   );

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  ram_wr_en, ram_addr, ram_addr_sel, ram_wr_data,
      output ram_data_in
   );
endinterface

// File: rtl/lsu_biu.sv
// Load/store bus interface unit: size/offset to RAM byte lanes, store data lane shift, load extension.
// Latency: aligned = 1 RAM beat, response from cycle 2; split = 2 beats, response from cycle 3.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: clk, rst_n (async active-low), bus (lsu_biu_if.slave: req_*, rsp_*, ram_*).
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats;
// without it such accesses complete with rsp_err and no RAM access.
module lsu_biu #(
   parameter int ADDR_W = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   lsu_biu_if.slave  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       hi_q, hi_d;
   logic              err_q, err_d;

   // 8-byte lane mask across two consecutive words: bits [3:0] beat0, [7:4] beat1.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [7:0] m;
      case (size)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m << off;
   endfunction

   logic [7:0]        mask_q;
   logic              req_bad;
   logic [4:0]        lane_sh;
   logic [63:0]       wdata64;
   logic [31:0]       rd_word;
   logic [31:0]       load_ext;
   logic [ADDR_W-1:0] beat0_addr;
   logic [ADDR_W-1:0] beat1_addr;

   assign mask_q  = lane_mask(size_q, addr_q[1:0]);
   assign lane_sh = {addr_q[1:0], 3'b000};
   assign wdata64 = {32'd0, wdata_q} << lane_sh;
   assign rd_word = 32'({hi_q, lo_q} >> lane_sh);
   assign beat0_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign beat1_addr = beat0_addr + ADDR_W'(4);  // wraps at the top of the address space

`ifdef LSU_MISALIGN_SPLIT_EN
   assign req_bad = (bus.req_size == 2'b11);
`else
   logic [7:0] req_mask;
   assign req_mask = lane_mask(bus.req_size, bus.req_addr[1:0]);
   assign req_bad  = (bus.req_size == 2'b11) || (req_mask[7:4] != 4'd0);
`endif

   always_comb begin
      load_ext = rd_word;
      case (size_q)
         2'b00:   load_ext = uns_q ? {24'd0, rd_word[7:0]}  : {{24{rd_word[7]}},  rd_word[7:0]};
         2'b01:   load_ext = uns_q ? {16'd0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
         default: load_ext = rd_word;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      size_d   = size_q;
      uns_d    = uns_q;
      wdata_d  = wdata_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      err_d    = err_q;
      bus.req_ready    = 1'b0;
      bus.rsp_valid    = 1'b0;
      bus.rsp_rdata    = 32'd0;
      bus.rsp_err      = 1'b0;
      bus.ram_wr_en    = 1'b0;
      bus.ram_addr     = '0;
      bus.ram_addr_sel = 4'd0;
      bus.ram_wr_data  = 32'd0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               wdata_d = bus.req_wdata;
               lo_d    = 32'd0;
               hi_d    = 32'd0;
               err_d   = req_bad;
               state_d = req_bad ? RESP : BEAT0;
            end
         end
         BEAT0: begin
            bus.ram_addr     = beat0_addr;
            bus.ram_addr_sel = mask_q[3:0];
            bus.ram_wr_en    = we_q;
            bus.ram_wr_data  = wdata64[31:0];
            if (!we_q) lo_d = bus.ram_data_in;
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = (mask_q[7:4] != 4'd0) ? BEAT1 : RESP;
`else
            state_d = RESP;
`endif
         end
         BEAT1: begin
            bus.ram_addr     = beat1_addr;
            bus.ram_addr_sel = mask_q[7:4];
            bus.ram_wr_en    = we_q;
            bus.ram_wr_data  = wdata64[63:32];
            if (!we_q) hi_d = bus.ram_data_in;
            state_d = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            bus.rsp_rdata = (err_q || we_q) ? 32'd0 : load_ext;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         wdata_q <= 32'd0;
         lo_q    <= 32'd0;
         hi_q    <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/lsu_biu.md
# lsu_biu

Load/store bus interface unit between the CPU memory stage and the byte-lane data RAM. Accepts one load or store per valid/ready handshake and converts size and address into RAM byte-lane selects, lane-shifted write data and a word-aligned RAM address. Loads are returned sign- or zero-extended through a held response channel. Misaligned accesses are split into two RAM beats when the feature is compiled in.

## Interface
- ADDR_W, 32, request/RAM address width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal size or unsupported misalignment
- ram_wr_en  out  1  RAM write strobe
- ram_addr  out  ADDR_W  word-aligned RAM address, bits [1:0] always 0
- ram_addr_sel  out  4  byte-lane enables, bit n = bits [8n+7:8n]
- ram_wr_data  out  32  lane-positioned write data
- ram_data_in  in  32  combinational RAM read word; RAM returns 0 while ram_wr_en = 1

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready = 1. On req_valid, latch we/addr/size/unsigned/wdata and go to BEAT0; illegal size or unsupported misalignment goes directly to RESP with the error set.
- Offset a = addr[1:0]. 8-byte mask M = (size mask 0001/0011/1111) << a. Beat0 sel = M[3:0], beat1 sel = M[7:4].
- Store data: W64 = {32'b0, wdata << 0} << (8·a). Beat0 drives W64[31:0], beat1 drives W64[63:32]. Byte stores replicate nothing; unused lanes are don't-care but driven as W64 bits.
- BEAT0: ram_addr = {addr[31:2],2'b00}, ram_addr_sel = M[3:0], ram_wr_en = we. On a load, capture ram_data_in at the clock edge. Go to BEAT1 if M[7:4] ≠ 0, else RESP.
- BEAT1: ram_addr = beat0 address + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000). ram_addr_sel = M[7:4]. Capture the upper word on a load. Go to RESP.
- Load result: R64 = {upper, lower} >> (8·a). Take R64 low 8/16/32 bits and sign- or zero-extend to 32.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready, then the FSM goes to IDLE. No new request is accepted in the same cycle.
- Outside BEAT0/BEAT1: ram_wr_en = 0, ram_addr_sel = 0, ram_addr = 0, ram_wr_data = 0.
- Illegal size (11): no RAM access, rsp_err = 1, rsp_rdata = 0.

## Timing
- Reset values: FSM in IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; all ram_* outputs = 0.
- Aligned access: handshake at edge 0, RAM beat in cycle 1, rsp_valid from cycle 2.
- Split access: beats in cycles 1–2, rsp_valid from cycle 3.
- Throughput: one request every 3 cycles when aligned with rsp_ready held high; 4 cycles when split.
- RAM write occurs at the rising edge that ends each BEAT cycle.
- Reset asserted mid-operation returns the FSM to IDLE immediately and zeroes all outputs.
  - A split store interrupted after BEAT0 leaves the beat0 bytes written. This is accepted behaviour.
- ram_* outputs are combinational from state and latched request registers only; they do not depend on the current req_*.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned half/word accesses are split into two beats as described above.
- LSU_MISALIGN_SPLIT_EN undefined: any access with M[7:4] ≠ 0 goes IDLE → RESP with rsp_err = 1, rsp_rdata = 0 and no RAM access. BEAT1 is unreachable.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load byte at 0x13 with signed extension. Required: store beat has sel = 1111, addr = 0x10; load returns 0xFFFFFFDE, rsp_err = 0.
- Store half 0x8001 at 0x22, then load half at 0x22 with unsigned extension. Required: store sel = 1100, wr_data[31:16] = 0x8001; load returns 0x00008001.
- Split (macro on): store word 0x11223344 at 0x05. Required: beat0 addr 0x04, sel 1110, data[31:8] = 0x223344; beat1 addr 0x08, sel 0001, data[7:0] = 0x11. A word load at 0x05 then returns 0x11223344 in cycle 3.
- Macro off: load word at 0x06. Required: rsp_err = 1, rsp_rdata = 0, ram_addr_sel stays 0 for the whole transaction.
- Hold rsp_ready = 0 for 5 cycles after an aligned load. Required: rsp_valid and rsp_rdata stay stable, req_ready = 0 throughout, and the FSM returns to IDLE one cycle after rsp_ready rises.
- Assert rst_n low during BEAT1 of a split store at 0xFFFFFFFF. Required: beat0 targets 0xFFFFFFFC and beat1 targets 0x00000000. After reset, all outputs are 0 and req_ready = 1.
